run_detect_ctrl: RTL and testbench

RUN_DETECT_CTRL -- requirements
Module: run_detect_ctrl

---
 rtl/run_detect_ctrl_pkg.sv | 13 +
 rtl/run_detect_ctrl_run_counter.sv | 41 ++++
 rtl/run_detect_ctrl.sv | 149 ++++++++++++++
 tb/tb_run_detect_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/run_detect_ctrl_pkg.sv
// Shared definitions for the run detector: FSM state encodings and the minimum run length.
package run_detect_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StCount  = 2'd2,
        StLocked = 2'd3
    } state_e;

    localparam int unsigned RUN_MIN = 2;

endpackage

// File: rtl/run_detect_ctrl_run_counter.sv
// Run tracker: remembers the last sampled bit and counts consecutive equal bits, saturating.
module run_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clr,
    input  logic             restart,
    input  logic             inc,
    input  logic             w,
    output logic [CNT_W-1:0] run,
    output logic [CNT_W-1:0] run_inc,
    output logic             last
);

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    logic [CNT_W-1:0] run_q;
    logic             last_q;

    // Saturating increment, also used by the controller to decide z ahead of the edge.
    assign run_inc = (run_q == '1) ? run_q : run_q + One;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else if (clr) begin
            run_q <= '0;
        end else if (restart) begin
            run_q  <= One;
            last_q <= w;
        end else if (inc) begin
            run_q <= run_inc;
        end
    end

    assign run  = run_q;
    assign last = last_q;

endmodule

// File: rtl/run_detect_ctrl.sv
// Serial run-length detector: pulses hit when a run of equal bits reaches the programmed
// length, counts hits, and locks out after a programmable number of hits.
module run_detect_ctrl
    import run_detect_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             arm,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             w,
    input  logic [CNT_W-1:0] run_len,
    input  logic [CNT_W-1:0] max_hits,
    output logic             z,
    output logic             hit,
    output logic [CNT_W-1:0] hits,
    output logic [1:0]       state,
    output logic             locked
);

    localparam logic [CNT_W-1:0] One    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RunMin = CNT_W'(RUN_MIN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hits_q, hits_d, hits_inc;
    logic             z_q, z_d;
    logic             hit_q, hit_d;
    logic             locked_q;

    logic [CNT_W-1:0] leff, run, run_inc;
    logic             last;
    logic             cnt_clr, cnt_restart, cnt_inc;
    logic             match, hit_event, lock_event;

    run_counter #(
        .CNT_W (CNT_W)
    ) u_run_counter (
        .Clock   (Clock),
        .Reset   (Reset),
        .clr     (cnt_clr),
        .restart (cnt_restart),
        .inc     (cnt_inc),
        .w       (w),
        .run     (run),
        .run_inc (run_inc),
        .last    (last)
    );

    assign leff     = (run_len < RunMin) ? RunMin : run_len;
    assign match    = bit_valid && (w == last);
    assign hits_inc = (hits_q == '1) ? hits_q : hits_q + One;

    // Hit only on the step from Leff-1 to Leff, so a shortened run_len never fires retroactively.
    assign hit_event  = (state_q == StCount) && !clear && arm && match && (run == leff - One);
    assign lock_event = hit_event && (max_hits != '0) && (hits_inc == max_hits);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            hits_q   <= '0;
            z_q      <= 1'b0;
            hit_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hits_q   <= hits_d;
            z_q      <= z_d;
            hit_q    <= hit_d;
            locked_q <= (state_d == StLocked);
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (arm) state_d = StArmed;
                StArmed:  if (!arm) state_d = StIdle;
                          else if (bit_valid) state_d = StCount;
                StCount:  if (!arm) state_d = StIdle;
                          else if (lock_event) state_d = StLocked;
                StLocked: state_d = StLocked;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_clr     = 1'b0;
        cnt_restart = 1'b0;
        cnt_inc     = 1'b0;
        z_d         = z_q;
        hit_d       = 1'b0;
        hits_d      = hits_q;
        if (clear) begin
            cnt_clr = 1'b1;
            z_d     = 1'b0;
            hits_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StArmed: begin
                    if (arm && bit_valid) begin
                        cnt_restart = 1'b1;
                        z_d         = 1'b0;
                    end
                end
                StCount: begin
                    if (!arm) begin
                        cnt_clr = 1'b1;
                        z_d     = 1'b0;
                    end else if (bit_valid) begin
                        if (match) begin
                            cnt_inc = 1'b1;
                            z_d     = (run_inc >= leff);
                            if (hit_event) begin
                                hit_d  = 1'b1;
                                hits_d = hits_inc;
                            end
                        end else begin
                            cnt_restart = 1'b1;
                            z_d         = 1'b0;
                        end
                    end
                end
                StLocked: begin
                    cnt_clr = 1'b1;
                    z_d     = 1'b0;
                end
                default: begin
                    cnt_clr = 1'b1;
                    z_d     = 1'b0;
                end
            endcase
        end
    end

    assign z      = z_q;
    assign hit    = hit_q;
    assign hits   = hits_q;
    assign state  = state_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Directed bench for run_detect_ctrl with hand-computed expectations.
module tb_run_detect_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       arm;
    logic       clear;
    logic       bit_valid;
    logic       w;
    logic [3:0] run_len;
    logic [3:0] max_hits;
    logic       z;
    logic       hit;
    logic [3:0] hits;
    logic [1:0] state;
    logic       locked;

    int vectors = 0;
    int errors  = 0;

    run_detect_ctrl #(
        .CNT_W (4)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .arm       (arm),
        .clear     (clear),
        .bit_valid (bit_valid),
        .w         (w),
        .run_len   (run_len),
        .max_hits  (max_hits),
        .z         (z),
        .hit       (hit),
        .hits      (hits),
        .state     (state),
        .locked    (locked)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one edge; outputs are sampled 1ns after it.
    task automatic step(input logic bv, input logic wb);
        bit_valid = bv;
        w         = wb;
        @(posedge Clock);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1'b0, 1'b0);
        clear = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; arm = 1'b0; clear = 1'b0; bit_valid = 1'b0; w = 1'b0;
        run_len = 4'd4; max_hits = 4'd0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_state", state, 0);
        chk("rst_z", z, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hits", hits, 0);
        chk("rst_locked", locked, 0);

        // Run of four 1s with L=4
        Reset = 1'b0; arm = 1'b1;
        step(1'b0, 1'b0);
        chk("arm_state", state, 1);
        step(1'b1, 1'b1);
        chk("r1_state", state, 2);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("r3_hit", hit, 0);
        chk("r3_z", z, 0);
        step(1'b1, 1'b1);
        chk("r4_hit", hit, 1);
        chk("r4_z", z, 1);
        chk("r4_hits", hits, 1);
        step(1'b0, 1'b0);
        chk("idle_hit", hit, 0);
        chk("idle_z", z, 1);

        // 0,0,0,1,1,1,1,1 with L=4
        pulse_clear();
        chk("clr_hits", hits, 0);
        chk("clr_state", state, 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("b3_hit", hit, 0);
        step(1'b1, 1'b1);
        chk("b4_z", z, 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("b6_hit", hit, 0);
        step(1'b1, 1'b1);
        chk("b7_hit", hit, 1);
        chk("b7_z", z, 1);
        step(1'b1, 1'b1);
        chk("b8_hit", hit, 0);
        chk("b8_z", z, 1);
        chk("b8_hits", hits, 1);

        // run_len=1 clamps to 2
        pulse_clear();
        step(1'b0, 1'b0);
        run_len = 4'd1;
        step(1'b1, 1'b1);
        chk("l1_b1_hit", hit, 0);
        step(1'b1, 1'b1);
        chk("l1_b2_hit", hit, 1);
        chk("l1_b2_z", z, 1);

        // Lockout after two hits
        pulse_clear();
        run_len = 4'd2; max_hits = 4'd2;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("lk_b2_hits", hits, 1);
        step(1'b1, 1'b0);
        chk("lk_b3_z", z, 0);
        step(1'b1, 1'b0);
        chk("lk_b4_hit", hit, 1);
        chk("lk_b4_hits", hits, 2);
        chk("lk_b4_state", state, 3);
        chk("lk_b4_locked", locked, 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("lk_ign_hit", hit, 0);
        chk("lk_ign_z", z, 0);
        chk("lk_ign_hits", hits, 2);
        arm = 1'b0;
        step(1'b0, 1'b0);
        chk("lk_arm0_state", state, 3);
        pulse_clear();
        chk("lk_clr_state", state, 0);
        chk("lk_clr_hits", hits, 0);
        chk("lk_clr_locked", locked, 0);

        // arm=0 mid-run, then Reset together with clear
        arm = 1'b1; max_hits = 4'd0; run_len = 4'd4;
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("mr_hits", hits, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        arm = 1'b0;
        step(1'b1, 1'b0);
        chk("mr_state", state, 0);
        chk("mr_hit", hit, 0);
        chk("mr_hits_kept", hits, 1);
        chk("mr_z", z, 0);
        Reset = 1'b1; clear = 1'b1; arm = 1'b1;
        step(1'b1, 1'b1);
        Reset = 1'b0; clear = 1'b0;
        chk("rc_state", state, 0);
        chk("rc_hits", hits, 0);
        chk("rc_z", z, 0);
        chk("rc_hit", hit, 0);
        chk("rc_locked", locked, 0);

        // 16 two-bit runs with L=2: hits saturates at 15
        run_len = 4'd2;
        step(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'(i % 2));
            step(1'b1, 1'(i % 2));
            chk("sat_hit", hit, 1);
            chk("sat_hits", hits, (i < 15) ? i + 1 : 15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
